// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 16x16 unsigned shift-and-add multiplier.
// It borrows the shared 33-bit ALU for all arithmetic:
//   - a 32-bit ADD accumulates the partial product;
//   - a 32-bit LSL doubles the multiplicand.
// The ALU output is registered, so every ALU operation takes an
// ISSUE cycle followed by a WAIT cycle.
//
// Optional build macro: ALU_MUL_EARLY_TERM_EN.
//   When defined, the block finishes as soon as no multiplier bits remain.
//   An OpB of zero therefore completes in a single cycle.
//
// State table:
//   state       | meaning
//   S_IDLE      | waiting for Start; ALU outputs parked at 0
//   S_ADD_ISSUE | drive P + M onto the ALU
//   S_ADD_WAIT  | capture the ALU sum into P
//   S_SHL_ISSUE | drive M << 1 onto the ALU
//   S_SHL_WAIT  | capture the shifted M, shift Q, count down one iteration
//   S_DONE      | Product valid, one-cycle Done pulse

module alu_mul_sequencer #(
  parameter int         N        = 16,
  parameter logic [4:0] FS_ADD32 = 5'b10100,
  parameter logic [4:0] FS_LSL32 = 5'b11011
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [N-1:0]   OpA,
  input  logic [N-1:0]   OpB,
  output logic           Busy,
  output logic           Done,
  output logic [2*N-1:0] Product,
  output logic [32:0]    AluA,
  output logic [32:0]    AluB,
  output logic [4:0]     AluFunSel,
  output logic           AluWF,
  input  logic [32:0]    AluOut
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADD_ISSUE = 3'd1,
    S_ADD_WAIT  = 3'd2,
    S_SHL_ISSUE = 3'd3,
    S_SHL_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic [2*N-1:0] p;
  logic [2*N-1:0] m;
  logic [N-1:0]   q;
  logic [N-1:0]   q_shr;
  logic [CW-1:0]  cnt;
  logic           start_zero;
  logic           last_iter;
  logic           alu_out_unused;

  assign q_shr = q >> 1;

  // The product never needs more than 2N bits.
  // The ALU carry and any upper result bits are therefore dropped.
  assign alu_out_unused = ^AluOut[32:2*N];

`ifdef ALU_MUL_EARLY_TERM_EN
  assign start_zero = (OpB == '0);
  assign last_iter  = (cnt == CW'(1)) || (q_shr == '0);
`else
  assign start_zero = 1'b0;
  assign last_iter  = (cnt == CW'(1));
`endif

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (start_zero)  state_nxt = S_DONE;
          else if (OpB[0]) state_nxt = S_ADD_ISSUE;
          else             state_nxt = S_SHL_ISSUE;
        end
      end
      S_ADD_ISSUE: state_nxt = S_ADD_WAIT;
      S_ADD_WAIT:  state_nxt = S_SHL_ISSUE;
      S_SHL_ISSUE: state_nxt = S_SHL_WAIT;
      S_SHL_WAIT: begin
        // q[1] is the multiplier bit that the shift is about to expose.
        if (last_iter) state_nxt = S_DONE;
        else if (q[1]) state_nxt = S_ADD_ISSUE;
        else           state_nxt = S_SHL_ISSUE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status and ALU operand outputs.
  // Operands stay stable through each WAIT cycle.
  always_comb begin
    Busy      = (state != S_IDLE);
    Done      = (state == S_DONE);
    AluA      = '0;
    AluB      = '0;
    AluFunSel = 5'b00000;
    case (state)
      S_ADD_ISSUE, S_ADD_WAIT: begin
        AluA      = 33'(p);
        AluB      = 33'(m);
        AluFunSel = FS_ADD32;
      end
      S_SHL_ISSUE, S_SHL_WAIT: begin
        AluA      = 33'(m);
        AluFunSel = FS_LSL32;
      end
      default: ;
    endcase
  end

  // Flags (and with them the ADD carry-in) must stay untouched.
  assign AluWF = 1'b0;

  // Datapath: operand latch, ALU result capture, iteration count, product.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      p       <= '0;
      m       <= '0;
      q       <= '0;
      cnt     <= '0;
      Product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            m   <= {{N{1'b0}}, OpA};
            q   <= OpB;
            p   <= '0;
            cnt <= CW'(N);
            if (start_zero) Product <= '0;
          end
        end
        S_ADD_WAIT: p <= AluOut[2*N-1:0];
        S_SHL_WAIT: begin
          m   <= AluOut[2*N-1:0];
          q   <= q_shr;
          cnt <= cnt - CW'(1);
          // P is already final here, so Product is valid on entry to DONE.
          if (last_iter) Product <= p;
        end
        default: ;
      endcase
    end
  end

endmodule
